// File: rtl/calc_pkg.sv
// Shared definitions for the keypad-driven signed BCD calculator front-end:
// key codes, entry-state encoding and key classification.
package calc_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_MINUS = 4'hB;
    localparam logic [3:0] KEY_EQ    = 4'hC;
    localparam logic [3:0] KEY_CLR   = 4'hD;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] A_DONE  = 3'd1;
    localparam logic [2:0] B_ENTRY = 3'd2;
    localparam logic [2:0] B_DONE  = 3'd3;
    localparam logic [2:0] PRESENT = 3'd4;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/present_timer.sv
// Counts cycles spent presenting an operand set; expired flags the last
// allowed cycle. A TIMEOUT of zero means the timer never expires.
module present_timer #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TMR_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/operand_entry.sv
// Keypad front-end: assembles sign/digit for A, an operator and sign/digit
// for B, then offers the pair downstream with the operator folded into B's sign.
module operand_entry
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TMR_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       a_sign,
    output logic [3:0] a_digit,
    output logic       b_sign,
    output logic [3:0] b_digit,
    output logic       operands_valid,
    input  logic       operands_ack,
    output logic       err
);

    logic [2:0] state_q, state_d;
    logic       a_sign_q, a_sign_d;
    logic [3:0] a_digit_q, a_digit_d;
    logic       b_neg_q, b_neg_d;
    logic [3:0] b_digit_q, b_digit_d;
    logic       op_sub_q, op_sub_d;
    logic       err_q, err_d;
    logic       valid_q;
    logic       b_sign_q;
    logic       tmr_expired;
    logic       flush;

    logic key_dig, key_plus, key_minus, key_eq, key_clr;

    assign key_dig   = key_valid && is_digit(key_code);
    assign key_plus  = key_valid && (key_code == KEY_PLUS);
    assign key_minus = key_valid && (key_code == KEY_MINUS);
    assign key_eq    = key_valid && (key_code == KEY_EQ);
    assign key_clr   = key_valid && (key_code == KEY_CLR);

    present_timer #(
        .TIMEOUT(TIMEOUT),
        .TMR_W  (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != PRESENT),
        .en     (state_q == PRESENT),
        .expired(tmr_expired)
    );

    // Leaving PRESENT (ack or timeout) and clear both wipe the operand set.
    assign flush = key_clr || ((state_q == PRESENT) && (operands_ack || tmr_expired));

    always_comb begin
        state_d   = state_q;
        a_sign_d  = a_sign_q;
        a_digit_d = a_digit_q;
        b_neg_d   = b_neg_q;
        b_digit_d = b_digit_q;
        op_sub_d  = op_sub_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (key_minus) a_sign_d = ~a_sign_q;
                if (key_dig) begin
                    a_digit_d = key_code;
                    state_d   = A_DONE;
                end
            end
            A_DONE: begin
                if (key_dig) a_digit_d = key_code;
                if (key_plus || key_minus) begin
                    op_sub_d = key_minus;
                    state_d  = B_ENTRY;
                end
                if (key_eq) err_d = 1'b1;
            end
            B_ENTRY: begin
                if (key_minus) b_neg_d = ~b_neg_q;
                if (key_dig) begin
                    b_digit_d = key_code;
                    state_d   = B_DONE;
                end
                if (key_plus || key_eq) err_d = 1'b1;
            end
            B_DONE: begin
                if (key_dig) b_digit_d = key_code;
                if (key_eq) state_d = PRESENT;
                if (key_plus || key_minus) err_d = 1'b1;
            end
            PRESENT: begin
                if (!operands_ack && tmr_expired) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            a_sign_d  = 1'b0;
            a_digit_d = 4'd0;
            b_neg_d   = 1'b0;
            b_digit_d = 4'd0;
            op_sub_d  = 1'b0;
        end
        if (key_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sign_q  <= 1'b0;
            a_digit_q <= 4'd0;
            b_neg_q   <= 1'b0;
            b_digit_q <= 4'd0;
            op_sub_q  <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            b_sign_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sign_q  <= a_sign_d;
            a_digit_q <= a_digit_d;
            b_neg_q   <= b_neg_d;
            b_digit_q <= b_digit_d;
            op_sub_q  <= op_sub_d;
            err_q     <= err_d;
            valid_q   <= (state_d == PRESENT);
            b_sign_q  <= b_neg_d ^ op_sub_d;
        end
    end

    assign a_sign         = a_sign_q;
    assign a_digit        = a_digit_q;
    assign b_sign         = b_sign_q;
    assign b_digit        = b_digit_q;
    assign operands_valid = valid_q;
    assign err            = err_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed scenarios plus random key
// streams, all checked against a phase-level model of the keypad rules.
module tb_operand_entry;

    localparam int TIMEOUT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       operands_ack = 1'b0;
    logic       a_sign, b_sign, operands_valid, err;
    logic [3:0] a_digit, b_digit;

    int n_tests = 0;
    int n_fail  = 0;

    operand_entry #(.TIMEOUT(TIMEOUT), .TMR_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .a_sign        (a_sign),
        .a_digit       (a_digit),
        .b_sign        (b_sign),
        .b_digit       (b_digit),
        .operands_valid(operands_valid),
        .operands_ack  (operands_ack),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Reference model: entry phase, operand values as integers and the operator.
    typedef enum int {M_IDLE, M_A, M_BENTRY, M_BDONE, M_PRES} mphase_t;
    mphase_t m_ph;
    int  m_a_neg, m_a_dig, m_b_neg, m_b_dig, m_minus_op, m_err, m_pcount;

    function automatic void model_wipe(input bit keep_err);
        m_ph = M_IDLE; m_a_neg = 0; m_a_dig = 0; m_b_neg = 0; m_b_dig = 0;
        m_minus_op = 0; m_pcount = 0;
        if (!keep_err) m_err = 0;
    endfunction

    function automatic void model_step(input bit kv, input int code, input bit ack);
        bit dig;
        dig = kv && code <= 9;
        if (kv && code == 13) begin
            model_wipe(0);
            return;
        end
        case (m_ph)
            M_IDLE: begin
                if (kv && code == 11) m_a_neg = 1 - m_a_neg;
                if (dig) begin m_a_dig = code; m_ph = M_A; end
            end
            M_A: begin
                if (dig) m_a_dig = code;
                if (kv && (code == 10 || code == 11)) begin
                    m_minus_op = (code == 11); m_ph = M_BENTRY;
                end
                if (kv && code == 12) m_err = 1;
            end
            M_BENTRY: begin
                if (kv && code == 11) m_b_neg = 1 - m_b_neg;
                if (dig) begin m_b_dig = code; m_ph = M_BDONE; end
                if (kv && (code == 10 || code == 12)) m_err = 1;
            end
            M_BDONE: begin
                if (dig) m_b_dig = code;
                if (kv && code == 12) begin m_ph = M_PRES; m_pcount = 0; end
                if (kv && (code == 10 || code == 11)) m_err = 1;
            end
            M_PRES: begin
                if (ack) model_wipe(1);
                else if (m_pcount == TIMEOUT - 1) begin model_wipe(1); m_err = 1; end
                else m_pcount++;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [3:0] ad, bd;
        ad = 4'(m_a_dig);
        bd = 4'(m_b_dig);
        // Effective B sign: a negative B subtracted is a positive addend.
        return {m_a_neg[0], ad, (m_b_neg != m_minus_op), bd, (m_ph == M_PRES), m_err[0]};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {a_sign, a_digit, b_sign, b_digit, operands_valid, err};
    endfunction

    task automatic cyc(input bit kv, input logic [3:0] code, input bit ack);
        key_valid = kv; key_code = code; operands_ack = ack;
        @(posedge clk);
        model_step(kv, int'(code), ack);
        #1;
        key_valid = 1'b0; key_code = 4'd0; operands_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_wipe(0);
        #12;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_entry_ack();
        logic [3:0] seq [7] = '{4'hB, 4'h7, 4'hB, 4'h3, 4'hC, 4'h0, 4'h0};
        bit         kvs [7] = '{1, 1, 1, 1, 1, 0, 0};
        bit         acks[7] = '{0, 0, 0, 0, 0, 0, 1};
        int vcnt = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(kvs[i], seq[i], acks[i]);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL entry_ack step %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (operands_valid) vcnt++;
        end
        n_tests++;
        if (vcnt !== 2) begin
            n_fail++;
            $display("FAIL entry_ack valid_cycles: got %0d expected 2", vcnt);
        end
    endtask

    task automatic test_sign_folding();
        logic [3:0] seq [14] = '{4'h4, 4'hB, 4'hB, 4'h9, 4'hC,
                                 4'h4, 4'hA, 4'h9, 4'hC,
                                 4'h4, 4'hB, 4'h9, 4'hC, 4'h0};
        for (int i = 0; i < 14; i++) begin
            // Ack arrives on the first presenting cycle of each set.
            cyc(i != 13, seq[i], m_ph == M_PRES);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sign_fold step %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_seq_errors();
        logic [3:0] seq [9] = '{4'hD, 4'h4, 4'hC, 4'hA, 4'hA, 4'h5, 4'hB, 4'hE, 4'hD};
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, seq[i], 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL seq_err step %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] seq [5] = '{4'hD, 4'h1, 4'hA, 4'h2, 4'hC};
        int vcnt = 0;
        for (int i = 0; i < 5; i++) cyc(1'b1, seq[i], 1'b0);
        if (operands_valid) vcnt++;
        for (int i = 0; i < 10 && operands_valid; i++) begin
            cyc(1'b0, 4'h0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (operands_valid) vcnt++;
        end
        n_tests++;
        if (vcnt !== TIMEOUT || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout valid_cycles/err: got %0d/%b expected %0d/1", vcnt, err, TIMEOUT);
        end
        // Ack lands on the same edge the timer would abort.
        for (int i = 0; i < 5; i++) cyc(1'b1, seq[i], 1'b0);
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc(1'b0, 4'h0, i == TIMEOUT - 1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ack_vs_timeout step %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clear_ack();
        logic [3:0] seq [6] = '{4'hD, 4'h1, 4'hC, 4'hA, 4'h2, 4'hC};
        for (int i = 0; i < 6; i++) cyc(1'b1, seq[i], 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL clear_ack present: got %h expected %h", obs_vec(), exp_vec());
        end
        cyc(1'b1, 4'hD, 1'b1);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL clear_ack idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq [5] = '{4'h2, 4'hA, 4'h2, 4'hC, 4'h0};
        cyc(1'b1, 4'h1, 1'b0);
        cyc(1'b1, 4'hA, 1'b0);
        cyc(1'b1, 4'hB, 1'b0);
        #2;
        rst_n = 1'b0;
        model_wipe(0);
        #1;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mid async: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(i != 4, seq[i], i == 4);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] code;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 39));
            if (r < 20)      code = 4'($urandom_range(0, 9));
            else if (r < 26) code = 4'hA;
            else if (r < 32) code = 4'hB;
            else if (r < 37) code = 4'hC;
            else if (r < 38) code = 4'hD;
            else             code = 4'($urandom_range(14, 15));
            cyc($urandom_range(0, 3) != 0, code, $urandom_range(0, 5) == 0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_wipe(0);
        test_reset();
        test_entry_ack();
        test_sign_folding();
        test_seq_errors();
        test_timeout();
        test_clear_ack();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
